dmem_responder: RTL and testbench

Memory-side responder for the multi-cycle CPU's data-memory interface. Receives the active-low nRD/nWR strobes, address and store data driven from the control/datapath side, inserts a configurable number of wait states, then performs the access and signals completion with a one-cycle Ready pulse. Holds word storage internally and sits between the control unit's memory strobes and the datapath's DBDataSrc read-back mux.

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/dmem_responder_if.sv | 25 ++
 rtl/dmem_array.sv | 76 +++++++
 rtl/dmem_responder.sv | 141 ++++++++++++++
 tb/tb_dmem_responder.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data-memory responder.
// Optional feature macro used by the slice: DMEM_PARITY_EN (per-word even parity).
package dmem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESP    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    // Even parity: the stored bit makes the total number of ones even.
    function automatic logic even_par(input logic [WORD_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: strobe/address/data bundle between the CPU side (master)
// and the memory responder (slave).
interface dmem_responder_if
    import dmem_pkg::*;
();
    logic              nRD;
    logic              nWR;
    logic [WORD_W-1:0] Addr;
    logic [WORD_W-1:0] DataIn;
    logic [WORD_W-1:0] DataOut;
    logic              Ready;
    logic              Busy;
    logic              AddrErr;
    logic              ParityErr;

    modport master (
        output nRD, nWR, Addr, DataIn,
        input  DataOut, Ready, Busy, AddrErr, ParityErr
    );

    modport slave (
        input  nRD, nWR, Addr, DataIn,
        output DataOut, Ready, Busy, AddrErr, ParityErr
    );
endinterface

// File: rtl/dmem_array.sv
// dmem_array: DEPTH_WORDS-deep word storage with synchronous write and a
// registered read port that holds its value between reads.
// With DMEM_PARITY_EN defined each word carries an even-parity bit that is
// checked on every read; otherwise perr_o is tied low.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o,
    output logic              perr_o
);

    logic [WORD_W-1:0] rdata_q;

`ifdef DMEM_PARITY_EN
    logic [WORD_W:0] mem_q [DEPTH_WORDS];
    logic [WORD_W:0] rd_word;
    logic            perr_q;

    assign rd_word = mem_q[addr_i];

    // Storage write: data plus its parity bit; contents are never cleared.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= {even_par(wdata_i), wdata_i};
        end
    end

    // Read register and one-cycle parity-error pulse aligned with the loaded word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            perr_q <= 1'b0;
            if (re_i) begin
                rdata_q <= rd_word[WORD_W-1:0];
                perr_q  <= (even_par(rd_word[WORD_W-1:0]) != rd_word[WORD_W]);
            end
        end
    end

    assign perr_o = perr_q;
`else
    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

    // Storage write; contents are never cleared.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read register: loads only on a read, otherwise holds the last word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign perr_o = 1'b0;
`endif

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the multi-cycle CPU data bus.
// Captures an nRD/nWR request, waits WAIT_CYCLES, performs the access with a
// one-cycle Ready pulse, then holds Busy until both strobes are released.
// Bad requests (misaligned, out of range, both strobes low) pulse AddrErr instead.
// Optional: DMEM_PARITY_EN enables per-word parity and the ParityErr pulse.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             CLK,
    input  logic             Reset,
    dmem_responder_if.slave  bus
);

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
    localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic              ready_q;
    logic              busy_q;
    logic              aerr_q;
    op_t               op_q;
    logic [AW-1:0]     idx_q;
    logic [WORD_W-1:0] data_q;

    logic              rd_req;
    logic              wr_req;
    logic              req;
    logic              bad;
    logic [AW-1:0]     idx_in;
    logic              acc_idle;
    logic              acc_wait;
    logic              we;
    logic              re;
    logic [AW-1:0]     acc_idx;
    logic [WORD_W-1:0] acc_data;
    logic [WORD_W-1:0] rdata;
    logic              perr;

    // Request decode, error check and the array access for the RESP-entry edge.
    always_comb begin
        rd_req   = ~bus.nRD;
        wr_req   = ~bus.nWR;
        req      = rd_req | wr_req;
        idx_in   = bus.Addr[AW+1:2];
        bad      = (rd_req & wr_req) | (|bus.Addr[1:0]) | (|bus.Addr[WORD_W-1:AW+2]);
        // Zero wait states: the capture edge itself enters RESP, so use live inputs.
        acc_idle = (state_q == IDLE) && req && !bad && NO_WAIT;
        acc_wait = (state_q == WAIT) && (cnt_q == 4'd1);
        // Reset on the RESP-entry edge suppresses the access.
        we       = !Reset && ((acc_idle && wr_req) || (acc_wait && op_q == OP_WR));
        re       = !Reset && ((acc_idle && rd_req) || (acc_wait && op_q == OP_RD));
        acc_idx  = acc_idle ? idx_in : idx_q;
        acc_data = acc_idle ? bus.DataIn : data_q;
    end

    // Latch address, store data and operation at request capture.
    always_ff @(posedge CLK) begin
        if (state_q == IDLE && req && !bad) begin
            idx_q  <= idx_in;
            data_q <= bus.DataIn;
            op_q   <= bus.nWR ? OP_RD : OP_WR;
        end
    end

    // Control FSM with wait counter and registered Ready/Busy/AddrErr.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            aerr_q  <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            aerr_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        busy_q <= 1'b1;
                        if (bad) begin
                            state_q <= RELEASE;
                            aerr_q  <= 1'b1;
                        end else if (NO_WAIT) begin
                            state_q <= RESP;
                            ready_q <= 1'b1;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= WAIT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd1) begin
                        state_q <= RESP;
                        ready_q <= 1'b1;
                        cnt_q   <= 4'd0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    state_q <= RELEASE;
                end
                RELEASE: begin
                    if (bus.nRD && bus.nWR) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk    (CLK),
        .rst    (Reset),
        .we_i   (we),
        .re_i   (re),
        .addr_i (acc_idx),
        .wdata_i(acc_data),
        .rdata_o(rdata),
        .perr_o (perr)
    );

    assign bus.DataOut   = rdata;
    assign bus.Ready     = ready_q;
    assign bus.Busy      = busy_q;
    assign bus.AddrErr   = aerr_q;
    assign bus.ParityErr = perr;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder with WAIT_CYCLES=2
// (dut) and WAIT_CYCLES=0 (dut0). Expected responses are queued when a
// request is driven and checked when Ready/AddrErr pulses appear.
// Parity scenario depends on DMEM_PARITY_EN.
module tb_dmem_responder;
    import dmem_pkg::*;

    logic CLK = 1'b0;
    logic Reset;

    always #5 CLK = ~CLK;

    dmem_responder_if bus ();
    dmem_responder_if bus0 ();

    dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut (
        .CLK(CLK), .Reset(Reset), .bus(bus)
    );

    dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
        .CLK(CLK), .Reset(Reset), .bus(bus0)
    );

    typedef struct {
        bit          is_err;
        bit          is_rd;
        logic [31:0] data;
        bit          perr;
        int          cyc;
    } exp_t;

    exp_t        q2[$];
    exp_t        q0[$];
    logic [31:0] last_dout[2];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Compare one Ready/AddrErr pulse against the head of the matching queue.
    task automatic on_pulse(input int w, input logic rdy, input logic aerr,
                            input logic perr, input logic [31:0] dout);
        exp_t e;
        int   k;
        k = (w == 0) ? 0 : 1;
        if ((w == 0 && q0.size() == 0) || (w != 0 && q2.size() == 0)) begin
            chk($sformatf("unexp_pulse_w%0d", w), {rdy, aerr}, 2'b00);
            return;
        end
        e = (w == 0) ? q0.pop_front() : q2.pop_front();
        chk($sformatf("lat_w%0d", w), cyc, e.cyc);
        chk($sformatf("aerr_w%0d", w), aerr, e.is_err);
        chk($sformatf("ready_w%0d", w), rdy, !e.is_err);
        if (e.is_rd && !e.is_err) begin
            chk($sformatf("data_w%0d", w), dout, e.data);
            chk($sformatf("perr_w%0d", w), perr, e.perr);
            last_dout[k] = e.data;
        end else begin
            chk($sformatf("dout_hold_w%0d", w), dout, last_dout[k]);
            chk($sformatf("perr_idle_w%0d", w), perr, 1'b0);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge CLK) begin
        if (Reset) begin
            last_dout[0] = 32'h0;
            last_dout[1] = 32'h0;
        end else begin
            if (bus.Ready || bus.AddrErr) on_pulse(2, bus.Ready, bus.AddrErr, bus.ParityErr, bus.DataOut);
            if (bus0.Ready || bus0.AddrErr) on_pulse(0, bus0.Ready, bus0.AddrErr, bus0.ParityErr, bus0.DataOut);
            if (!bus.Ready && bus.ParityErr) chk("perr_stray_w2", 1'b1, 1'b0);
            if (!bus0.Ready && bus0.ParityErr) chk("perr_stray_w0", 1'b1, 1'b0);
        end
    end

    task automatic drive(input int w, input logic nrd, input logic nwr,
                         input logic [31:0] a, input logic [31:0] d);
        if (w == 0) begin
            bus0.nRD = nrd; bus0.nWR = nwr; bus0.Addr = a; bus0.DataIn = d;
        end else begin
            bus.nRD = nrd; bus.nWR = nwr; bus.Addr = a; bus.DataIn = d;
        end
    endtask

    function automatic logic busy_of(input int w);
        return (w == 0) ? bus0.Busy : bus.Busy;
    endfunction

    // One access: w is the wait-state count of the target DUT (0 or 2).
    task automatic acc(input int w, input logic nrd, input logic nwr,
                       input logic [31:0] a, input logic [31:0] d, input int hold,
                       input bit is_err, input logic [31:0] ed, input bit ep);
        exp_t e;
        bit   idle_seen;
        @(negedge CLK);
        drive(w, nrd, nwr, a, d);
        e.is_err = is_err;
        e.is_rd  = !nrd && nwr;
        e.data   = ed;
        e.perr   = ep;
        e.cyc    = cyc + 1 + (is_err ? 0 : w);
        if (w == 0) q0.push_back(e); else q2.push_back(e);
        @(negedge CLK);
        chk($sformatf("busy_rise_w%0d", w), busy_of(w), 1'b1);
        repeat (hold - 1) @(negedge CLK);
        drive(w, 1'b1, 1'b1, 32'h0, 32'h0);
        if (hold >= w + 2) begin
            @(negedge CLK);
            chk($sformatf("busy_fall_w%0d", w), busy_of(w), 1'b0);
        end
        idle_seen = 1'b0;
        for (int i = 0; i < 40 && !idle_seen; i++) begin
            @(negedge CLK);
            if (!busy_of(w)) idle_seen = 1'b1;
        end
        if (!idle_seen) chk($sformatf("idle_timeout_w%0d", w), 1'b0, 1'b1);
    endtask

    // Write on dut, then reset dly cycles after the capture edge.
    task automatic abort_wr(input logic [31:0] a, input logic [31:0] d, input int dly);
        @(negedge CLK);
        drive(2, 1'b1, 1'b0, a, d);
        repeat (dly) @(negedge CLK);
        Reset = 1'b1;
        drive(2, 1'b1, 1'b1, 32'h0, 32'h0);
        @(negedge CLK);
        Reset = 1'b0;
        chk("abort_busy", bus.Busy, 1'b0);
        chk("abort_ready", bus.Ready, 1'b0);
        repeat (4) @(negedge CLK);
    endtask

    initial begin
        Reset = 1'b1;
        drive(2, 1'b1, 1'b1, 32'h0, 32'h0);
        drive(0, 1'b1, 1'b1, 32'h0, 32'h0);
        repeat (3) @(negedge CLK);
        chk("rst_dout", bus.DataOut, 32'h0);
        chk("rst_ready", bus.Ready, 1'b0);
        chk("rst_busy", bus.Busy, 1'b0);
        chk("rst_aerr", bus.AddrErr, 1'b0);
        chk("rst_perr", bus.ParityErr, 1'b0);
        chk("rst_dout0", bus0.DataOut, 32'h0);
        chk("rst_busy0", bus0.Busy, 1'b0);
        Reset = 1'b0;

        // Write then read back with two wait states.
        acc(2, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1, 1'b0, 32'h0, 1'b0);
        acc(2, 1'b0, 1'b1, 32'h10, 32'h0, 1, 1'b0, 32'hDEADBEEF, 1'b0);

        // Long-held read strobe: one Ready only, Busy until release.
        acc(2, 1'b1, 1'b0, 32'h4, 32'h0BADF00D, 1, 1'b0, 32'h0, 1'b0);
        acc(2, 1'b0, 1'b1, 32'h4, 32'h0, 10, 1'b0, 32'h0BADF00D, 1'b0);

        // Error requests, then the earlier word is intact.
        acc(2, 1'b0, 1'b1, 32'h12, 32'h0, 1, 1'b1, 32'h0, 1'b0);
        acc(2, 1'b1, 1'b0, 32'h100, 32'h55555555, 4, 1'b1, 32'h0, 1'b0);
        acc(2, 1'b0, 1'b0, 32'h10, 32'h11111111, 1, 1'b1, 32'h0, 1'b0);
        acc(2, 1'b0, 1'b1, 32'h10, 32'h0, 1, 1'b0, 32'hDEADBEEF, 1'b0);

        // Zero wait states.
        acc(0, 1'b1, 1'b0, 32'h8, 32'h12345678, 1, 1'b0, 32'h0, 1'b0);
        acc(0, 1'b0, 1'b1, 32'h8, 32'h0, 3, 1'b0, 32'h12345678, 1'b0);
        acc(0, 1'b0, 1'b1, 32'h3, 32'h0, 1, 1'b1, 32'h0, 1'b0);

        // Reset during WAIT and on the RESP-entry edge both drop the write.
        acc(2, 1'b1, 1'b0, 32'h20, 32'h11112222, 1, 1'b0, 32'h0, 1'b0);
        acc(2, 1'b1, 1'b0, 32'h24, 32'h33334444, 1, 1'b0, 32'h0, 1'b0);
        abort_wr(32'h20, 32'hAAAA5555, 1);
        abort_wr(32'h24, 32'hAAAA5555, 2);
        acc(2, 1'b0, 1'b1, 32'h20, 32'h0, 1, 1'b0, 32'h11112222, 1'b0);
        acc(2, 1'b0, 1'b1, 32'h24, 32'h0, 1, 1'b0, 32'h33334444, 1'b0);

        // Parity: corrupt one stored bit when parity storage exists.
        acc(2, 1'b1, 1'b0, 32'h30, 32'h0F0F0F0F, 1, 1'b0, 32'h0, 1'b0);
`ifdef DMEM_PARITY_EN
        dut.u_array.mem_q[12][3] = ~dut.u_array.mem_q[12][3];
        acc(2, 1'b0, 1'b1, 32'h30, 32'h0, 1, 1'b0, 32'h0F0F0F07, 1'b1);
`else
        acc(2, 1'b0, 1'b1, 32'h30, 32'h0, 1, 1'b0, 32'h0F0F0F0F, 1'b0);
`endif

        repeat (3) @(negedge CLK);
        chk("q2_drained", q2.size(), 0);
        chk("q0_drained", q0.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time guard.
    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
